// File: rtl/sr_hyp_unit.sv
// sr_hyp_unit: multi-cycle floor(sqrt(a*a + b*b)) unit for the HYP instruction.
// Define SR_HYP_COMB_MUL_EN for single-cycle combinational squaring stages.
module sr_hyp_unit #(
    parameter int IN_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam int AW = 2 * IN_W + 2;
    localparam int RW = IN_W + 4;
    localparam int CW = $clog2(IN_W + 2);
    typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, SQRT, DONE} state_t;
    state_t state, state_nxt;
    // acc carries one spare top bit so the radicand splits into whole bit pairs
    logic [AW-1:0]   acc;
    logic [IN_W-1:0] q, rb;
    logic [RW-3:0]   rem;
    logic [RW-1:0]   rem_sh, trial, rem_nxt;
    logic [IN_W:0]   root, root_nxt;
    logic [CW-1:0]   cnt;
    logic            mul_last, sqrt_last, fits;
    logic            unused_bits;
`ifndef SR_HYP_COMB_MUL_EN
    logic [AW-1:0]   m;
`endif
    assign unused_bits = ^{a[31:IN_W], b[31:IN_W], rem_nxt[RW-1:RW-2]};
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign sqrt_last   = cnt == CW'(IN_W);
`ifdef SR_HYP_COMB_MUL_EN
    assign mul_last    = 1'b1;
`else
    assign mul_last    = cnt == CW'(IN_W - 1);
`endif
    always_comb begin
        rem_sh   = {rem, acc[AW-1:AW-2]};
        trial    = {1'b0, root, 2'b01};
        fits     = rem_sh >= trial;
        rem_nxt  = fits ? rem_sh - trial : rem_sh;
        root_nxt = {root[IN_W-1:0], fits};
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? MUL_A : IDLE;
            MUL_A:   state_nxt = mul_last ? MUL_B : MUL_A;
            MUL_B:   state_nxt = mul_last ? SQRT : MUL_B;
            SQRT:    state_nxt = sqrt_last ? DONE : SQRT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            q      <= '0;
            rb     <= '0;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            result <= '0;
`ifndef SR_HYP_COMB_MUL_EN
            m      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    q    <= a[IN_W-1:0];
                    rb   <= b[IN_W-1:0];
                    acc  <= '0;
                    rem  <= '0;
                    root <= '0;
                    cnt  <= '0;
`ifndef SR_HYP_COMB_MUL_EN
                    m    <= AW'(a[IN_W-1:0]);
`endif
                end
`ifdef SR_HYP_COMB_MUL_EN
                MUL_A: acc <= AW'(q) * AW'(q);
                MUL_B: acc <= acc + AW'(rb) * AW'(rb);
`else
                MUL_A, MUL_B: begin
                    acc <= q[0] ? acc + m : acc;
                    cnt <= mul_last ? '0 : cnt + CW'(1);
                    m   <= (mul_last && state == MUL_A) ? AW'(rb) : m << 1;
                    q   <= (mul_last && state == MUL_A) ? rb : q >> 1;
                end
`endif
                SQRT: begin
                    acc  <= acc << 2;
                    rem  <= rem_nxt[RW-3:0];
                    root <= root_nxt;
                    cnt  <= cnt + CW'(1);
                    if (sqrt_last) result <= 32'(root_nxt);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_hyp_unit.sv
// tb_sr_hyp_unit: directed self-checking bench for sr_hyp_unit.
// Expected latency follows the SR_HYP_COMB_MUL_EN build setting.
module tb_sr_hyp_unit;
`ifdef SR_HYP_COMB_MUL_EN
    localparam int LAT = 20;
`else
    localparam int LAT = 50;
`endif
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;
    int          errors = 0;
    int          checks = 0;

    sr_hyp_unit #(.IN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Issue one operation; lat counts falling edges from the accept edge to done.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output bit busy_hi);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        busy_hi = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!busy) busy_hi = 1'b0;
        end while (!done && lat < 300);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat; bit bh;
        run_op(32'd3, 32'd4, lat, bh);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        checks++; if (result !== 32'd5) begin errors++; $display("FAIL basic_result: got %0d want 5", result); end
        checks++; if (bh !== 1'b1) begin errors++; $display("FAIL basic_busy_high: got %b want 1", bh); end
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic_busy_fall: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_zero();
        int lat; bit bh;
        run_op(32'd0, 32'd0, lat, bh);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL zero_result: got %0d want 0", result); end
    endtask

    task automatic test_max();
        int lat; bit bh;
        run_op(32'h0000FFFF, 32'h0000FFFF, lat, bh);
        checks++; if (result !== 32'h00016A08) begin errors++; $display("FAIL max_result: got %0d want 92680", result); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL max_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_upper_ignored();
        int lat; bit bh;
        run_op(32'h12340005, 32'hABCD000C, lat, bh);
        checks++; if (result !== 32'd13) begin errors++; $display("FAIL upper_ignored: got %0d want 13", result); end
    endtask

    task automatic test_busy_ignore();
        int lat, extra;
        @(negedge clk);
        a = 32'd6; b = 32'd8; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 10) begin a = 32'd1; b = 32'd1; start = 1'b1; end
            if (lat == 11) start = 1'b0;
        end while (!done && lat < 300);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
        checks++; if (result !== 32'd10) begin errors++; $display("FAIL ignore_result: got %0d want 10", result); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_fall: got %b want 0", busy); end
        extra = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_second_op: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_reset_abort();
        int lat, seen; bit bh;
        @(negedge clk);
        a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL abort_result: got %0d want 0", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        seen = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        rst_n = 1'b1;
        run_op(32'd5, 32'd12, lat, bh);
        checks++; if (result !== 32'd13) begin errors++; $display("FAIL abort_recover: got %0d want 13", result); end
    endtask

    task automatic test_back_to_back();
        int gap;
        @(negedge clk);
        a = 32'd6; b = 32'd8; start = 1'b1;
        gap = 0;
        do begin @(negedge clk); gap++; end while (!done && gap < 300);
        checks++; if (result !== 32'd10) begin errors++; $display("FAIL b2b_first: got %0d want 10", result); end
        a = 32'd5; b = 32'd12;
        gap = 0;
        do begin @(negedge clk); gap++; end while (!done && gap < 300);
        start = 1'b0;
        checks++; if (result !== 32'd13) begin errors++; $display("FAIL b2b_second: got %0d want 13", result); end
        checks++; if (gap !== LAT + 1) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", gap, LAT + 1); end
        repeat (LAT + 5) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_upper_ignored();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
